// File: rtl/cim_pkg.sv
// Shared geometry constants for the 3x3 compute-in-memory core and the
// PSUM collection path that sits behind it.
package cim_pkg;

  localparam int NUM_COL  = 3;
  localparam int NUM_ROW  = 3;
  localparam int NUM_LANE = 8;
  localparam int LANE_W   = 14;
  localparam int SUM_W    = LANE_W + 2;

  localparam int MACRO_W  = NUM_LANE * LANE_W;             // 112
  localparam int PSUM_W   = NUM_COL * NUM_ROW * MACRO_W;   // 1008
  localparam int COL_W    = NUM_LANE * SUM_W;              // 128
  localparam int REC_W    = NUM_COL * COL_W;               // 384

endpackage

// File: rtl/psum_fifo.sv
// Synchronous record FIFO with registered full/empty and a valid/ready pop
// side; push and pop may coincide at any occupancy, including full.
module psum_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 384,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop_ready,
  output logic              pop_valid,
  output logic [WIDTH-1:0]  pop_data,
  output logic [ADDR_W:0]   count
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   wr_next;
  logic [ADDR_W:0]   rd_next;
  logic              empty_q;
  logic              full_q;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = !empty_q && pop_ready;
  // A pop in the same cycle frees the slot the push needs, even when full.
  assign do_push = push && (!full_q || do_pop);

  assign wr_next = wr_ptr + {{ADDR_W{1'b0}}, do_push};
  assign rd_next = rd_ptr + {{ADDR_W{1'b0}}, do_pop};

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wr_ptr  <= wr_next;
      rd_ptr  <= rd_next;
      empty_q <= (wr_next == rd_next);
      full_q  <= (wr_next[ADDR_W] != rd_next[ADDR_W]) &&
                 (wr_next[ADDR_W-1:0] == rd_next[ADDR_W-1:0]);
    end
  end

  // NOTE: the storage array is deliberately not reset; the empty flag
  // already marks its contents invalid, and an unreset RAM maps to memory.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end
  end

  assign pop_valid = !empty_q;
  assign pop_data  = empty_q ? '0 : mem[rd_ptr[ADDR_W-1:0]];
  assign count     = wr_ptr - rd_ptr;

endmodule

// File: rtl/psum_collector.sv
// Deskews the three core columns, sums the three rows per column lane and
// queues the assembled 3-column record for a valid/ready consumer.
module psum_collector #(
  parameter int DEPTH  = 4,
  parameter int LANE_W = cim_pkg::LANE_W,
  parameter int SUM_W  = cim_pkg::SUM_W,
  localparam int MACRO_W = cim_pkg::NUM_LANE * LANE_W,
  localparam int PSUM_W  = cim_pkg::NUM_COL * cim_pkg::NUM_ROW * MACRO_W,
  localparam int COL_W   = cim_pkg::NUM_LANE * SUM_W,
  localparam int REC_W   = cim_pkg::NUM_COL * COL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [PSUM_W-1:0] psum_in,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REC_W-1:0]  out_data,
  output logic              err_overflow
);

  localparam int NUM_COL  = cim_pkg::NUM_COL;
  localparam int NUM_ROW  = cim_pkg::NUM_ROW;
  localparam int NUM_LANE = cim_pkg::NUM_LANE;
  localparam int ADDR_W   = $clog2(DEPTH);

  logic [REC_W-1:0]    col_sum;
  logic                vld_a;
  logic                vld_b;
  logic [COL_W-1:0]    sum_a;
  logic [2*COL_W-1:0]  sum_b;
  logic [REC_W-1:0]    wr_record;
  logic [ADDR_W:0]     fifo_count;
  logic [ADDR_W+1:0]   pending;

  // Row sums for every column of whatever the bus carries this cycle; each
  // pipeline stage picks only the column that belongs to its vector.
  // NOTE: col_sum gets a full default before the loops so no path through
  // this block can leave it unassigned and infer a latch.
  always_comb begin
    logic [SUM_W-1:0] acc;
    col_sum = '0;
    acc     = '0;
    for (int c = 0; c < NUM_COL; c++) begin
      for (int l = 0; l < NUM_LANE; l++) begin
        acc = '0;
        for (int r = 0; r < NUM_ROW; r++) begin
          acc = acc + SUM_W'(psum_in[(r*NUM_COL + c)*MACRO_W + l*LANE_W +: LANE_W]);
        end
        col_sum[(c*NUM_LANE + l)*SUM_W +: SUM_W] = acc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_a        <= 1'b0;
      vld_b        <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      vld_a <= in_valid;
      vld_b <= vld_a;
      if (in_valid && !in_ready) begin
        err_overflow <= 1'b1;
      end
    end
  end

  // Partial records carry no meaning without their valid bit.
  always_ff @(posedge clk) begin
    sum_a <= col_sum[0 +: COL_W];
    sum_b <= {col_sum[COL_W +: COL_W], sum_a};
  end

  // Column 2 is summed straight off the bus in the cycle the record is written.
  assign wr_record = {col_sum[2*COL_W +: COL_W], sum_b};

  psum_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_b),
    .push_data (wr_record),
    .pop_ready (out_ready),
    .pop_valid (out_valid),
    .pop_data  (out_data),
    .count     (fifo_count)
  );

  // Reserve a slot for every vector still crossing the deskew stages.
  assign pending  = (ADDR_W+2)'(fifo_count) + (ADDR_W+2)'(vld_a) + (ADDR_W+2)'(vld_b);
  assign in_ready = pending < (ADDR_W+2)'(DEPTH);

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: a cycle-level occupancy model and a
// record scoreboard predict in_ready, out_valid, err_overflow and out_data.
module tb_psum_collector;

  localparam int DEPTH    = 4;
  localparam int LANE_W   = 14;
  localparam int SUM_W    = 16;
  localparam int NCOL     = 3;
  localparam int NROW     = 3;
  localparam int NLANE    = 8;
  localparam int MACRO_W  = NLANE * LANE_W;
  localparam int PSUM_W   = NCOL * NROW * MACRO_W;
  localparam int REC_W    = NCOL * NLANE * SUM_W;

  typedef logic [PSUM_W-1:0] img_t;
  typedef logic [REC_W-1:0]  rec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  img_t        psum_in;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  rec_t        out_data;
  logic        err_overflow;

  int tests = 0;
  int fails = 0;

  // model state
  rec_t sbq[$];
  int   occ;
  bit   pa, pb;
  rec_t rec_a, rec_b;
  bit   exp_err;
  img_t img0, img1, img2;

  psum_collector #(
    .DEPTH  (DEPTH),
    .LANE_W (LANE_W),
    .SUM_W  (SUM_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .psum_in      (psum_in),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input rec_t obs, input rec_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic img_t img_fill(input logic [LANE_W-1:0] v);
    img_t im = '0;
    for (int i = 0; i < NCOL*NROW*NLANE; i++) im[i*LANE_W +: LANE_W] = v;
    return im;
  endfunction

  // Every lane of every macro in column c carries vals[c].
  function automatic img_t img_cols(input int v0, input int v1, input int v2);
    img_t im = '0;
    int   v;
    for (int r = 0; r < NROW; r++)
      for (int c = 0; c < NCOL; c++) begin
        v = (c == 0) ? v0 : (c == 1) ? v1 : v2;
        for (int l = 0; l < NLANE; l++)
          im[(r*NCOL + c)*MACRO_W + l*LANE_W +: LANE_W] = LANE_W'(v);
      end
    return im;
  endfunction

  function automatic img_t img_rand();
    img_t im = '0;
    for (int i = 0; i < NCOL*NROW*NLANE; i++) im[i*LANE_W +: LANE_W] = LANE_W'($urandom);
    return im;
  endfunction

  function automatic rec_t rec_cols(input int s0, input int s1, input int s2);
    rec_t rc = '0;
    for (int c = 0; c < NCOL; c++)
      for (int l = 0; l < NLANE; l++)
        rc[(c*NLANE + l)*SUM_W +: SUM_W] = SUM_W'((c == 0) ? s0 : (c == 1) ? s1 : s2);
    return rc;
  endfunction

  function automatic rec_t model_sum(input img_t im);
    rec_t rc = '0;
    int   s;
    for (int c = 0; c < NCOL; c++)
      for (int l = 0; l < NLANE; l++) begin
        s = 0;
        for (int r = 0; r < NROW; r++)
          s += int'(im[(r*NCOL + c)*MACRO_W + l*LANE_W +: LANE_W]);
        rc[(c*NLANE + l)*SUM_W +: SUM_W] = SUM_W'(s);
      end
    return rc;
  endfunction

  // Column c of the bus carries the vector issued c cycles ago.
  function automatic img_t compose(input img_t i0, input img_t i1, input img_t i2);
    img_t b = '0;
    for (int r = 0; r < NROW; r++) begin
      b[(r*NCOL + 0)*MACRO_W +: MACRO_W] = i0[(r*NCOL + 0)*MACRO_W +: MACRO_W];
      b[(r*NCOL + 1)*MACRO_W +: MACRO_W] = i1[(r*NCOL + 1)*MACRO_W +: MACRO_W];
      b[(r*NCOL + 2)*MACRO_W +: MACRO_W] = i2[(r*NCOL + 2)*MACRO_W +: MACRO_W];
    end
    return b;
  endfunction

  function automatic bit model_ready();
    return (occ + int'(pa) + int'(pb)) < DEPTH;
  endfunction

  // One clock cycle: drive, check current outputs against the model, advance.
  task automatic cycle(input bit v, input img_t im, input rec_t exp_rec, input bit rdy);
    bit exp_ir, pop, push;
    exp_ir    = model_ready();
    out_ready = rdy;
    in_valid  = v;
    img2      = img1;
    img1      = img0;
    img0      = v ? im : '0;
    psum_in   = compose(img0, img1, img2);
    #1;
    check("in_ready", rec_t'(in_ready), rec_t'(exp_ir));
    check("out_valid", rec_t'(out_valid), rec_t'(occ > 0));
    check("err_overflow", rec_t'(err_overflow), rec_t'(exp_err));
    if (occ > 0) check("out_data", out_data, sbq[0]);
    pop  = (occ > 0) && rdy;
    push = pb && ((occ < DEPTH) || pop);
    if (pop) void'(sbq.pop_front());
    if (push) sbq.push_back(rec_b);
    occ   = occ + int'(push) - int'(pop);
    pb    = pa;
    rec_b = rec_a;
    pa    = v;
    rec_a = exp_rec;
    if (v && !exp_ir) exp_err = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, rdy);
  endtask

  task automatic issue_rand(input bit rdy);
    img_t im;
    im = img_rand();
    cycle(1'b1, im, model_sum(im), rdy);
  endtask

  task automatic model_clear();
    sbq.delete();
    occ = 0; pa = 0; pb = 0; exp_err = 0;
    rec_a = '0; rec_b = '0;
    img0 = '0; img1 = '0; img2 = '0;
  endtask

  // Asynchronous reset pulse: outputs must clear before any clock edge.
  task automatic reset_pulse();
    rst      = 1'b1;
    in_valid = 1'b0;
    psum_in  = '0;
    #1;
    check("rst_out_valid", rec_t'(out_valid), '0);
    check("rst_in_ready", rec_t'(in_ready), rec_t'(1'b1));
    check("rst_err", rec_t'(err_overflow), '0);
    check("rst_out_data", out_data, '0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int issued;
    bit go;
    img_t im;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    psum_in   = '0;
    model_clear();
    #2;
    reset_pulse();

    // Single vector, all lanes 100 -> 300 everywhere, visible at t+3.
    cycle(1'b1, img_fill(14'd100), rec_cols(300, 300, 300), 1'b1);
    idle(5, 1'b1);

    // Maximum lane values must not wrap.
    cycle(1'b1, img_fill(14'd16383), rec_cols(49149, 49149, 49149), 1'b1);
    idle(5, 1'b1);

    // Column skew: distinct per-column values land in the right column.
    cycle(1'b1, img_cols(1, 2, 3), rec_cols(3, 6, 9), 1'b1);
    idle(5, 1'b1);

    // Back-to-back random vectors with an always-ready consumer.
    for (int i = 0; i < 6; i++) issue_rand(1'b1);
    idle(5, 1'b1);

    // Backpressure: 6 vectors offered only while ready; consumer stalled.
    issued = 0;
    for (int k = 0; k < 10; k++) begin
      go = (issued < 6) && model_ready();
      im = img_rand();
      cycle(go, im, model_sum(im), 1'b0);
      if (go) issued++;
    end
    for (int k = 0; k < 14; k++) begin
      go = (issued < 6) && model_ready();
      im = img_rand();
      cycle(go, im, model_sum(im), 1'b1);
      if (go) issued++;
    end

    // Fill the FIFO, then push into it while full: first with a same-cycle
    // pop (kept), then without one (dropped). Both raise err_overflow.
    for (int k = 0; k < 6; k++) begin
      go = model_ready();
      im = img_rand();
      cycle(go, im, model_sum(im), 1'b0);
    end
    issue_rand(1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    issue_rand(1'b0);
    idle(3, 1'b0);
    idle(3, 1'b1);

    // Reset in the middle of traffic.
    issue_rand(1'b1);
    issue_rand(1'b1);
    reset_pulse();

    // Fresh vector after reset behaves like the first one.
    cycle(1'b1, img_cols(5, 0, 100), rec_cols(15, 0, 300), 1'b1);
    idle(5, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 Parameter DEPTH, default 4, output FIFO entries (power of 2, 2..16).
REQ-002 Parameter LANE_W, default 14, bit width of one macro PSUM lane.
REQ-003 Parameter SUM_W, default 16, bit width of one collected lane sum (LANE_W+2).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  an activation vector is driven into column 0 of the 3x3 core this cycle.
REQ-007 psum_in  input  1008  core PSUM bus, 9 macros x 8 lanes x 14b; macro (col c, row r) at bits [(r*3+c)*112 +: 112], lane l at +l*14.
REQ-008 in_ready  output  1  high when a new vector may be issued (FIFO occupancy + in-flight < DEPTH).
REQ-009 out_valid  output  1  out_data holds a collected result.
REQ-010 out_ready  input  1  downstream accepts out_data.
REQ-011 out_data  output  384  3 columns x 8 lanes x SUM_W; column c lane l at bits [(c*8+l)*16 +: 16].
REQ-012 err_overflow  output  1  sticky: in_valid seen while in_ready low.

Function
REQ-013 Column c of the core presents the PSUM for a vector issued at cycle t during cycle t+c; the block SHALL deskew by sampling column c's lanes at cycle t+c.
REQ-014 Per column c, lane l: sum = zero-extended PSUM(c,row0,l) + PSUM(c,row1,l) + PSUM(c,row2,l), unsigned, SUM_W bits, no saturation (max 3*16383=49149 fits).
REQ-015 Deskew pipeline: 3-deep valid shift register; stage A captures column-0 sums at t, stage B adds column-1 sums at t+1, column-2 sums sampled at t+2 and the full 384b record written to FIFO on the t+2 rising edge.
REQ-016 Latency: in_valid at cycle t with empty FIFO -> out_valid high in cycle t+3 with that record.
REQ-017 Back-to-back in_valid every cycle SHALL be supported; records leave in issue order.
REQ-018 FIFO pop on out_valid && out_ready; out_data/out_valid stay stable while out_valid && !out_ready.
REQ-019 Push and pop in the same cycle SHALL be allowed at any occupancy including full; occupancy unchanged.
REQ-020 In-flight count = number of set bits in the valid shift register; in_ready = (occupancy + in-flight) < DEPTH, combinational from registers only (no path from in_valid).
REQ-021 in_valid while in_ready low: vector still tracked if a slot exists at write time; otherwise record dropped, FIFO contents untouched; err_overflow set in both cases.
REQ-022 FIFO read/write pointers wrap modulo DEPTH; full/empty distinguished by an extra pointer bit.
REQ-023 out_data is don't-care when out_valid low; bench SHALL not check it.

Reset
REQ-024 rst asserted: valid shift register cleared, FIFO emptied, out_valid=0, in_ready=1, err_overflow=0, out_data=0.
REQ-025 rst mid-operation discards all in-flight and buffered records; first in_valid after rst deasserts behaves per REQ-016.
REQ-026 err_overflow cleared only by rst.

Structure
REQ-027 Shared package cim_pkg SHALL hold NUM_COL=3, NUM_ROW=3, NUM_LANE=8, LANE_W, SUM_W and PSUM bus width 1008.
REQ-028 One sub-module psum_fifo (synchronous FIFO, DEPTH x 384, registered full/empty, valid/ready pop) SHALL implement buffering; deskew and adders stay in psum_collector.

Verification
REQ-029 Single vector: all 9 macros' lanes = 100 in the deskewed cycles, out_ready=1 -> out_valid in t+3 only, every lane sum = 300.
REQ-030 Max values: all lanes 16383 at their deskew cycles -> every sum = 49149, no wrap.
REQ-031 Column skew: col0 lanes=1 at t, col1=2 at t+1, col2=3 at t+2, all other cycles 0 -> column sums 3, 6, 9.
REQ-032 Backpressure: out_ready=0, 6 vectors issued whenever in_ready=1 -> in_ready drops after 4 issued, 4 records held stable, err_overflow=0; out_ready=1 -> 4 records in order, then remaining 2.
REQ-033 Full push+pop: FIFO full, out_ready=1, push same cycle -> occupancy stays 4, no loss, order kept.
REQ-034 Overflow/reset: in_valid with in_ready=0 -> err_overflow=1 next cycle; rst pulse mid-stream -> out_valid=0, in_ready=1, err_overflow=0 immediately.
